button_debounce_pulse: RTL and testbench

- Upstream conditioning stage for the LCD step state machine. It turns a raw, bouncing, asynchronous push-button into two outputs:
  - a clean debounced level;
  - a single-cycle press pulse.
- The pulse drives the step FSM's advance input, so one physical press advances exactly one state.
- Contents: 2-flop synchroniser, stability counter, 4-state debounce FSM.

---
 rtl/button_debounce_pulse_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/button_debounce_pulse.sv | 88 ++++++++
 tb/tb_button_debounce_pulse.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pulse_pkg.sv
// Shared encodings and defaults for the push-button conditioning stage.
// One-hot states line up with the step FSM that consumes the press pulse.
package button_debounce_pulse_pkg;

  typedef enum logic [3:0] {
    IDLE_LOW  = 4'b0001,
    WAIT_HIGH = 4'b0010,
    HELD_HIGH = 4'b0100,
    WAIT_LOW  = 4'b1000
  } db_state_t;

  // 10 ms of stable samples at 50 MHz
  localparam int STABLE_COUNT_50MHZ_10MS = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; both flops clear to 0 on reset.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync1, sync2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
    end
  end

  assign q = sync2;

endmodule

// File: rtl/button_debounce_pulse.sv
// Debounces a raw push-button into a clean level and a one-cycle press pulse,
// so each physical press advances the downstream step FSM exactly once.
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int STABLE_COUNT = STABLE_COUNT_50MHZ_10MS,
  parameter int CNT_WIDTH    = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic button_in,
  output logic level_out,
  output logic pulse_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 sync2;
  db_state_t            state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_d, level_d;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d     (button_in),
    .q     (sync2)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_out <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_out <= level_d;
      pulse_out <= pulse_d;
    end
  end

  // Counter holds the number of consecutive samples opposite to the accepted
  // level; it is cleared on every accept/abort so it never passes CNT_LAST.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    case (state_q)
      IDLE_LOW: begin
        if (sync2) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_d = IDLE_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD_HIGH;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD_HIGH: begin
        if (!sync2) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_d = HELD_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE_LOW;
    endcase
    level_d = (state_d == HELD_HIGH) || (state_d == WAIT_LOW);
  end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Bench for button_debounce_pulse with STABLE_COUNT=4: a constant table for the
// clean press, then a reference-model scoreboard for bounce, hold, release and reset.
module tb_button_debounce_pulse;

  localparam int SC = 4;
  localparam int CW = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic button_in = 1'b0;
  logic level_out, pulse_out;

  button_debounce_pulse #(.STABLE_COUNT(SC), .CNT_WIDTH(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .button_in (button_in),
    .level_out (level_out),
    .pulse_out (pulse_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic b;
    logic lvl;
    logic pls;
  } vec_t;

  typedef struct {
    logic lvl;
    logic pls;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[23];

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference: level flips once SC consecutive synchronised samples
  // disagree with it; a press pulse accompanies each flip to 1.
  logic m_s1, m_s2, m_level, m_pulse;
  int   m_run;
  logic got_l, got_p;

  task automatic m_reset();
    m_s1 = 0; m_s2 = 0; m_level = 0; m_pulse = 0; m_run = 0;
  endtask

  task automatic model_edge(input logic b);
    logic seen;
    seen    = m_s2;
    m_s2    = m_s1;
    m_s1    = b;
    m_pulse = 1'b0;
    if (seen != m_level) begin
      m_run++;
      if (m_run == SC) begin
        m_level = ~m_level;
        m_run   = 0;
        m_pulse = m_level;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic chk(input string nm, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  // Drive at posedge+1, push the expectation, pop and compare at next posedge+1.
  task automatic step(input logic b, input logic use_tbl, input logic tl,
                      input logic tp, input string nm);
    exp_t e;
    button_in = b;
    model_edge(b);
    if (use_tbl) e = '{lvl: tl, pls: tp};
    else         e = '{lvl: m_level, pls: m_pulse};
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    e     = exp_q.pop_front();
    got_l = level_out;
    got_p = pulse_out;
    chk(nm, {30'd0, got_l, got_p}, {30'd0, e.lvl, e.pls});
  endtask

  task automatic mid_reset(input string nm);
    #2 reset = 1'b1;
    #1 chk(nm, {30'd0, level_out, pulse_out}, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    m_reset();
  endtask

  initial begin
    int npulse, first_p, fall_i;

    for (int i = 0; i < 3; i++) tbl[i] = '{b: 1'b0, lvl: 1'b0, pls: 1'b0};
    for (int i = 0; i < 20; i++)
      tbl[3+i] = '{b: 1'b1, lvl: (i >= 5), pls: (i == 5)};

    m_reset();
    #12;
    chk("reset_state", {30'd0, level_out, pulse_out}, 0);
    @(posedge clock);
    #1 reset = 1'b0;

    // clean press: table expectations; edge 0 is the first sampling edge
    foreach (tbl[i]) step(tbl[i].b, 1'b1, tbl[i].lvl, tbl[i].pls, "clean_press");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "clean_release");
    chk("clean_release_level", {31'd0, got_l}, 0);

    // bounce: 3 high / 2 low, five times; never accepted
    npulse = 0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b1, 1'b0, 1'b0, 1'b0, "bounce");
        npulse += got_p + got_l;
      end
      for (int i = 0; i < 2; i++) begin
        step(1'b0, 1'b0, 1'b0, 1'b0, "bounce");
        npulse += got_p + got_l;
      end
    end
    chk("bounce_activity", npulse, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "bounce_tail");

    // long hold: exactly one pulse
    npulse = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, "long_hold");
      npulse += got_p;
    end
    chk("long_hold_pulses", npulse, 1);
    chk("long_hold_level", {31'd0, got_l}, 1);

    // release with a one-sample glitch back high
    npulse = 0;
    step(1'b0, 1'b0, 1'b0, 1'b0, "rel_glitch"); npulse += got_p;
    step(1'b0, 1'b0, 1'b0, 1'b0, "rel_glitch"); npulse += got_p;
    step(1'b1, 1'b0, 1'b0, 1'b0, "rel_glitch"); npulse += got_p;
    fall_i = -1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, "rel_final");
      npulse += got_p;
      if (fall_i < 0 && !got_l) fall_i = i;
    end
    chk("rel_no_pulse", npulse, 0);
    chk("rel_fall_edge", fall_i, 5);

    // async reset while held high, release with the button still pressed
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "pre_reset_hold");
    chk("pre_reset_level", {31'd0, got_l}, 1);
    mid_reset("async_reset_held");
    npulse = 0; first_p = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, "post_reset_press");
      npulse += got_p;
      if (first_p < 0 && got_p) first_p = i;
    end
    chk("post_reset_pulse_edge", first_p, 5);
    chk("post_reset_pulses", npulse, 1);

    // reset in WAIT_HIGH with count at 2
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "idle_again");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "wait_high");
    mid_reset("async_reset_wait_high");
    npulse = 0; first_p = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, "wait_high_restart");
      npulse += got_p;
      if (first_p < 0 && got_p) first_p = i;
    end
    chk("wait_high_restart_edge", first_p, 5);
    chk("wait_high_restart_pulses", npulse, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
